// File: rtl/sd_response_receiver_pkg.sv
// Shared definitions for the SD CMD-line response receiver: FSM encoding,
// frame geometry and the serial CRC7 step function.
package sd_response_receiver_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        RECEIVE,
        CHECK,
        DONE
    } state_t;

    localparam int FRAME_BITS           = 48;
    localparam int CRC_BITS             = 7;
    localparam logic [CRC_BITS-1:0] CRC7_POLY = 7'h09;
    localparam int TIMEOUT_BITS_DEFAULT = 64;

    // One MSB-first step of x^7 + x^3 + 1: shift left, fold feedback into taps 3 and 0.
    function automatic logic [CRC_BITS-1:0] crc7_next(input logic [CRC_BITS-1:0] crc,
                                                      input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[CRC_BITS-1];
        return {crc[CRC_BITS-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
    endfunction

endpackage

// File: rtl/sd_response_receiver_crc7.sv
// Serial CRC7 accumulator; clear has priority over enable.
module crc7_accumulator
    import sd_response_receiver_pkg::*;
(
    input  logic                clk,
    input  logic                clear,
    input  logic                enable,
    input  logic                bit_in,
    output logic [CRC_BITS-1:0] crc
);

    always_ff @(posedge clk) begin
        if (clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= crc7_next(crc, bit_in);
        end
    end

endmodule

// File: rtl/sd_response_receiver.sv
// Receives one 48-bit SD command response from the CMD line, checks CRC7,
// end bit and direction bit, and reports a start-bit timeout.
module sd_response_receiver
    import sd_response_receiver_pkg::*;
#(
    parameter int TIMEOUT_BITS = TIMEOUT_BITS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bit_en,
    input  logic        cmd_in,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [5:0]  resp_index,
    output logic [31:0] resp_arg,
    output logic        crc_ok,
    output logic        end_ok,
    output logic        dir_ok,
    output logic        timeout
);

    localparam int TCNT_W = $clog2(TIMEOUT_BITS + 1);
    localparam logic [TCNT_W-1:0] TIMEOUT_LAST = TCNT_W'(TIMEOUT_BITS - 1);
    localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);
    // Bits received before the first CRC field bit arrives (start bit + 39).
    localparam logic [5:0] CRC_SPAN = 6'(FRAME_BITS - CRC_BITS - 1);

    state_t                state;
    logic [5:0]            bit_cnt;
    logic [TCNT_W-1:0]     timeout_cnt;
    // Frame bits 46..0; the start bit (47) is always 0 and needs no storage.
    logic [FRAME_BITS-2:0] shift_reg;
    logic [CRC_BITS-1:0]   crc;
    logic                  crc_clear;
    logic                  crc_en;

    always_comb begin
        crc_clear = reset || (state == IDLE && start);
        crc_en    = 1'b0;
        if (bit_en) begin
            case (state)
                WAIT_START: crc_en = !cmd_in;
                RECEIVE:    crc_en = (bit_cnt < CRC_SPAN);
                default:    crc_en = 1'b0;
            endcase
        end
    end

    crc7_accumulator u_crc (
        .clk    (clk),
        .clear  (crc_clear),
        .enable (crc_en),
        .bit_in (cmd_in),
        .crc    (crc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            bit_cnt     <= '0;
            timeout_cnt <= '0;
            shift_reg   <= '0;
            resp_index  <= '0;
            resp_arg    <= '0;
            crc_ok      <= 1'b0;
            end_ok      <= 1'b0;
            dir_ok      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state       <= WAIT_START;
                        busy        <= 1'b1;
                        bit_cnt     <= '0;
                        timeout_cnt <= '0;
                        crc_ok      <= 1'b0;
                        end_ok      <= 1'b0;
                        dir_ok      <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end
                WAIT_START: begin
                    if (bit_en) begin
                        if (!cmd_in) begin
                            state     <= RECEIVE;
                            bit_cnt   <= 6'd1;
                            shift_reg <= {shift_reg[FRAME_BITS-3:0], cmd_in};
                        end else begin
                            timeout_cnt <= timeout_cnt + 1'b1;
                            if (timeout_cnt == TIMEOUT_LAST) begin
                                state   <= DONE;
                                done    <= 1'b1;
                                timeout <= 1'b1;
                            end
                        end
                    end
                end
                RECEIVE: begin
                    if (bit_en) begin
                        shift_reg <= {shift_reg[FRAME_BITS-3:0], cmd_in};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    crc_ok     <= (shift_reg[7:1] == crc);
                    end_ok     <= shift_reg[0];
                    dir_ok     <= !shift_reg[46];
                    resp_index <= shift_reg[45:40];
                    resp_arg   <= shift_reg[39:8];
                    state      <= DONE;
                    done       <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
